// File: rtl/fsm_rx_packer_if.sv
// Bus bundle between the RX packer, the serial RX front end and vector memory.
// The master modport is the packer side; slave is the front end / memory side.
interface fsm_rx_packer_if #(
  parameter int RX_W  = 8,
  parameter int BEATS = 2,
  parameter int DEPTH = 1024
) ();
  localparam int MEM_W  = RX_W * BEATS;
  localparam int ADDR_W = $clog2(DEPTH);

  // rx_ready qualifies rx_data for one cycle and has no back-pressure.
  // A memory write transfers on any clk edge with write_enable && write_ready;
  // write_addr/write_data stay stable while write_enable waits for write_ready.
  logic              rx_ready;
  logic [RX_W-1:0]   rx_data;
  logic              write_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [MEM_W-1:0]  write_data;

  modport master (
    input  rx_ready, rx_data, write_ready,
    output write_enable, write_addr, write_data
  );

  modport slave (
    output rx_ready, rx_data, write_ready,
    input  write_enable, write_addr, write_data
  );
endinterface

// File: rtl/fsm_rx_packer.sv
// Packs BEATS RX beats (LSB beat first) into memory words, writes DEPTH words per frame.
// Optional macro RX_CHECKSUM_EN adds rx_checksum, the XOR of all accepted beats in the frame.
module fsm_rx_packer #(
  parameter int RX_W  = 8,
  parameter int BEATS = 2,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  fsm_rx_packer_if.master     bus,
  output logic                busy,
  output logic                frame_done,
  output logic                overflow,
  output logic [1:0]          dbg_state
`ifdef RX_CHECKSUM_EN
  ,
  output logic [RX_W-1:0]     rx_checksum
`endif
);
  localparam int MEM_W  = RX_W * BEATS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [MEM_W-1:0]  data_q;
  logic              overflow_q;
  logic              last_beat;
  logic              last_addr;

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: begin
        if (start)                      state_d = COLLECT;
        else if (bus.rx_ready && last_beat) state_d = WRITE;
      end
      WRITE: begin
        // A restart wins over completion; the concurrent write still lands in memory.
        if (start)                state_d = COLLECT;
        else if (bus.write_ready) state_d = last_addr ? DONE : COLLECT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            beat_cnt_q <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (start) begin
            beat_cnt_q <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
          end else if (bus.rx_ready) begin
            for (int b = 0; b < BEATS; b++) begin
              if (beat_cnt_q == CNT_W'(b)) data_q[b*RX_W +: RX_W] <= bus.rx_data;
            end
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
          end
        end
        WRITE: begin
          if (start) begin
            beat_cnt_q <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
          end else begin
            // The last address is held so the frame never wraps.
            if (bus.write_ready && !last_addr) addr_q <= addr_q + ADDR_W'(1);
            if (bus.rx_ready) overflow_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RX_CHECKSUM_EN
  logic [RX_W-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start && state_q != DONE) begin
      csum_q <= '0;
    end else if (state_q == COLLECT && bus.rx_ready) begin
      csum_q <= csum_q ^ bus.rx_data;
    end
  end

  assign rx_checksum = csum_q;
`endif

  assign bus.write_enable = (state_q == WRITE);
  assign bus.write_addr   = addr_q;
  assign bus.write_data   = data_q;
  assign busy             = (state_q == COLLECT) || (state_q == WRITE);
  assign frame_done       = (state_q == DONE);
  assign overflow         = overflow_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_fsm_rx_packer.sv
// Self-checking bench for fsm_rx_packer with RX_W=8, BEATS=2, DEPTH=4.
module tb_fsm_rx_packer;
  localparam int W = 18;  // {addr[1:0], data[15:0]}

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       frame_done;
  logic       overflow;
  logic [1:0] dbg_state;
`ifdef RX_CHECKSUM_EN
  logic [7:0] rx_checksum;
`endif

  fsm_rx_packer_if #(.RX_W(8), .BEATS(2), .DEPTH(4)) bus ();

  fsm_rx_packer #(.RX_W(8), .BEATS(2), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
`ifdef RX_CHECKSUM_EN
    ,
    .rx_checksum(rx_checksum)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [W-1:0] exp;
  } vec_t;

  vec_t frame_vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Two beats, then one accepted write (write_ready must already be 1).
  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    drive_beat(b0);
    drive_beat(b1);
    chk("we_rise", {31'b0, bus.write_enable}, 32'd1);
    tick();
    chk("we_single", {31'b0, bus.write_enable}, 32'd0);
  endtask

  // scoreboard: every accepted write is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && bus.write_enable && bus.write_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 bus.write_addr, bus.write_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.write_addr, bus.write_data} !== e) begin
          failures++;
          $display("FAIL write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   bus.write_addr, bus.write_data, e[17:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    frame_vecs[0] = '{b0: 8'h00, b1: 8'h01, exp: {2'd0, 16'h0100}};
    frame_vecs[1] = '{b0: 8'h02, b1: 8'h03, exp: {2'd1, 16'h0302}};
    frame_vecs[2] = '{b0: 8'h04, b1: 8'h05, exp: {2'd2, 16'h0504}};
    frame_vecs[3] = '{b0: 8'h06, b1: 8'h07, exp: {2'd3, 16'h0706}};

    rst             = 1'b1;
    start           = 1'b0;
    bus.rx_ready    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.write_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_we", {31'b0, bus.write_enable}, 32'd0);
    chk("rst_addr", {30'b0, bus.write_addr}, 32'd0);
    chk("rst_data", {16'b0, bus.write_data}, 32'd0);
    chk("rst_flags", {29'b0, busy, frame_done, overflow}, 32'd0);

    // rx ignored in IDLE
    drive_beat(8'hAA);
    chk("idle_ignore_we", {31'b0, bus.write_enable}, 32'd0);
    chk("idle_ignore_state", {30'b0, dbg_state}, 32'd0);
    chk("idle_ignore_data", {16'b0, bus.write_data}, 32'd0);

    // single word with explicit output checks
    pulse_start();
    chk("start_busy", {31'b0, busy}, 32'd1);
    exp_q.push_back({2'd0, 16'h1234});
    drive_beat(8'h34);
    chk("mid_word_we", {31'b0, bus.write_enable}, 32'd0);
    drive_beat(8'h12);
    chk("single_we", {31'b0, bus.write_enable}, 32'd1);
    chk("single_addr", {30'b0, bus.write_addr}, 32'd0);
    chk("single_data", {16'b0, bus.write_data}, 32'h1234);
    tick();
    chk("single_we_drop", {31'b0, bus.write_enable}, 32'd0);
    chk("single_addr_inc", {30'b0, bus.write_addr}, 32'd1);

    // full frame from the vector table (start aborts the open frame)
    pulse_start();
    chk("restart_addr", {30'b0, bus.write_addr}, 32'd0);
    for (int i = 0; i < 4; i++) send_word(frame_vecs[i].b0, frame_vecs[i].b1, frame_vecs[i].exp);
    chk("done_pulse", {31'b0, frame_done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_addr_hold", {30'b0, bus.write_addr}, 32'd3);
    start = 1'b1;  // ignored in DONE
    tick();
    start = 1'b0;
    chk("done_one_cycle", {31'b0, frame_done}, 32'd0);
    chk("done_start_ignored", {30'b0, dbg_state}, 32'd0);

    // backpressure with beats arriving during WRITE
    pulse_start();
    bus.write_ready = 1'b0;
    exp_q.push_back({2'd0, 16'hB2A1});
    drive_beat(8'hA1);
    drive_beat(8'hB2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_we_hold", {31'b0, bus.write_enable}, 32'd1);
      chk("bp_addr_hold", {30'b0, bus.write_addr}, 32'd0);
      chk("bp_data_hold", {16'b0, bus.write_data}, 32'hB2A1);
      bus.rx_ready = 1'b1;
      bus.rx_data  = 8'hEE;
      tick();
    end
    bus.rx_ready = 1'b0;
    chk("bp_overflow", {31'b0, overflow}, 32'd1);
    chk("bp_data_clean", {16'b0, bus.write_data}, 32'hB2A1);
    bus.write_ready = 1'b1;
    tick();
    send_word(8'hC3, 8'hD4, {2'd1, 16'hD4C3});
    chk("overflow_sticky", {31'b0, overflow}, 32'd1);

    // abort after the write at address 1
    pulse_start();
    chk("abort_overflow", {31'b0, overflow}, 32'd0);
    chk("abort_addr", {30'b0, bus.write_addr}, 32'd0);
    chk("abort_state", {30'b0, dbg_state}, 32'd1);
    send_word(8'h22, 8'h11, {2'd0, 16'h1122});

    // start and rx_ready together: the beat is discarded
    drive_beat(8'h55);
    start        = 1'b1;
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h99;
    tick();
    start        = 1'b0;
    bus.rx_ready = 1'b0;
    send_word(8'h66, 8'h77, {2'd0, 16'h7766});

    // reset mid-frame
    drive_beat(8'h5A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", {30'b0, dbg_state}, 32'd0);
    chk("midrst_data", {16'b0, bus.write_data}, 32'd0);
    chk("midrst_addr", {30'b0, bus.write_addr}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);

`ifdef RX_CHECKSUM_EN
    pulse_start();
    chk("csum_clear", {24'b0, rx_checksum}, 32'd0);
    send_word(8'h01, 8'h02, {2'd0, 16'h0201});
    send_word(8'h04, 8'h08, {2'd1, 16'h0804});
    send_word(8'h10, 8'h20, {2'd2, 16'h2010});
    send_word(8'h40, 8'h80, {2'd3, 16'h8040});
    chk("csum_done", {31'b0, frame_done}, 32'd1);
    chk("csum_value", {24'b0, rx_checksum}, 32'hFF);
    tick();
    chk("csum_hold", {24'b0, rx_checksum}, 32'hFF);
`endif

    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
